seq_shift_unit: RTL and testbench

SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

---
 rtl/seq_shift_pkg.sv | 24 ++
 rtl/seq_shift_unit_shift_step.sv | 71 +++++++
 rtl/seq_shift_unit.sv | 113 +++++++++++
 tb/tb_seq_shift_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_shift_pkg.sv
// seq_shift_pkg: shared definitions for the sequential shift unit.
//   op_e    - OP encoding (LSR, LSL, ASR, ROR, ROL; other codes are no-ops)
//   state_e - control FSM states
//   seq_aw  - shift-amount width helper, $clog2(width)+1
package seq_shift_pkg;

  typedef enum logic [2:0] {
    OP_LSR = 3'b000,
    OP_LSL = 3'b001,
    OP_ASR = 3'b010,
    OP_ROR = 3'b100,
    OP_ROL = 3'b101
  } op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  function automatic int seq_aw(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_shift_unit_shift_step.sv
// shift_step: combinational single step of the sequential shifter.
//   i_word [WIDTH] - working word
//   i_op   [3]     - operation code (op_e encoding)
//   i_cnt  [AW]    - positions to shift this step (0..WIDTH; <WIDTH for rotates)
//   o_word [WIDTH] - shifted word
//   o_bit          - last bit shifted/rotated out (0 when i_cnt is 0)
// Macro SEQ_SHIFT_ROTATE_EN enables the ROR/ROL datapath.
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AW    = 5
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic [2:0]       i_op,
  input  logic [AW-1:0]    i_cnt,
  output logic [WIDTH-1:0] o_word,
  output logic             o_bit
);

  localparam logic [AW-1:0] ONE = AW'(1);

  logic [AW-1:0]    w_cm1;
  logic [WIDTH-1:0] w_pre_r;
  logic [WIDTH-1:0] w_pre_l;

  // The last bit out is the edge bit after shifting one position fewer.
  assign w_cm1   = i_cnt - ONE;
  assign w_pre_r = i_word >> w_cm1;
  assign w_pre_l = i_word << w_cm1;

`ifdef SEQ_SHIFT_ROTATE_EN
  logic [2*WIDTH-1:0] w_dbl_r;
  logic [2*WIDTH-1:0] w_dbl_l;
  assign w_dbl_r = {i_word, i_word} >> i_cnt;
  assign w_dbl_l = {i_word, i_word} << i_cnt;
`endif

  always_comb begin
    o_word = i_word;
    o_bit  = 1'b0;
    if (i_cnt != '0) begin
      case (i_op)
        OP_LSR: begin
          o_word = i_word >> i_cnt;
          o_bit  = w_pre_r[0];
        end
        OP_LSL: begin
          o_word = i_word << i_cnt;
          o_bit  = w_pre_l[WIDTH-1];
        end
        OP_ASR: begin
          o_word = $signed(i_word) >>> i_cnt;
          o_bit  = w_pre_r[0];
        end
`ifdef SEQ_SHIFT_ROTATE_EN
        OP_ROR: begin
          o_word = w_dbl_r[WIDTH-1:0];
          o_bit  = w_pre_r[0];
        end
        OP_ROL: begin
          o_word = w_dbl_l[2*WIDTH-1:WIDTH];
          o_bit  = w_pre_l[WIDTH-1];
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shifter, up to STEP positions per clock.
//   CLK, RST (async, active high)
//   start             - request, sampled only while idle
//   A, B [WIDTH]      - operands, SEL picks B when 1
//   OP [3]            - LSR/LSL/ASR/ROR/ROL, other codes are no-ops
//   AMT [AW]          - shift amount
//   busy              - operation in flight
//   shift_out [WIDTH] - result, held until next completion
//   carry             - last bit shifted out, updated with shift_out
//   shift_flag        - one-cycle completion pulse
// Macro SEQ_SHIFT_ROTATE_EN enables ROR/ROL; otherwise they act as no-ops.
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int STEP  = 1,
  localparam int AW    = seq_aw(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SEL,
  input  logic [2:0]       OP,
  input  logic [AW-1:0]    AMT,
  output logic             busy,
  output logic [WIDTH-1:0] shift_out,
  output logic             carry,
  output logic             shift_flag
);

  localparam logic [AW-1:0] W_AW    = AW'(WIDTH);
  localparam logic [AW-1:0] STEP_AW = AW'(STEP);

  state_e           r_state;
  logic [WIDTH-1:0] r_work;
  logic [2:0]       r_op;
  logic [AW-1:0]    r_rem;
  logic             r_cbit;

  logic [AW-1:0]    w_eff;
  logic [AW-1:0]    w_step;
  logic [WIDTH-1:0] w_next;
  logic             w_bit;

  always_comb begin
    w_eff = '0;
    case (OP)
      OP_LSR, OP_LSL, OP_ASR: w_eff = (AMT > W_AW) ? W_AW : AMT;
`ifdef SEQ_SHIFT_ROTATE_EN
      OP_ROR, OP_ROL:         w_eff = AMT % W_AW;
`endif
      default:                w_eff = '0;
    endcase
  end

  assign w_step = (r_rem > STEP_AW) ? STEP_AW : r_rem;

  shift_step #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_step (
    .i_word (r_work),
    .i_op   (r_op),
    .i_cnt  (w_step),
    .o_word (w_next),
    .o_bit  (w_bit)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_work     <= '0;
      r_op       <= '0;
      r_rem      <= '0;
      r_cbit     <= 1'b0;
      busy       <= 1'b0;
      shift_out  <= '0;
      carry      <= 1'b0;
      shift_flag <= 1'b0;
    end else begin
      shift_flag <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work  <= SEL ? B : A;
            r_op    <= OP;
            r_rem   <= w_eff;
            r_cbit  <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_rem != '0) begin
            r_work <= w_next;
            r_rem  <= r_rem - w_step;
            r_cbit <= w_bit;
          end else begin
            shift_out  <= r_work;
            carry      <= r_cbit;
            shift_flag <= 1'b1;
            busy       <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: directed checks of seq_shift_unit (WIDTH=16) with two
// instances sharing inputs, STEP=1 (u1) and STEP=4 (u4).
// Expectations for ROR/ROL follow SEQ_SHIFT_ROTATE_EN.
module tb_seq_shift_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        SEL = 1'b0;
  logic [2:0]  OP = '0;
  logic [4:0]  AMT = '0;

  logic        b1, c1, f1, b4, c4, f4;
  logic [15:0] so1, so4;

  int checks = 0;
  int errors = 0;
  int e1, e4, n1, n4, bc1, consec;
  logic p1 = 1'b0;
  logic p4 = 1'b0;

  always #5 CLK = ~CLK;

  seq_shift_unit #(.WIDTH(16), .STEP(1)) u1 (
    .CLK(CLK), .RST(RST), .start(start), .A(A), .B(B), .SEL(SEL), .OP(OP), .AMT(AMT),
    .busy(b1), .shift_out(so1), .carry(c1), .shift_flag(f1)
  );

  seq_shift_unit #(.WIDTH(16), .STEP(4)) u4 (
    .CLK(CLK), .RST(RST), .start(start), .A(A), .B(B), .SEL(SEL), .OP(OP), .AMT(AMT),
    .busy(b4), .shift_out(so4), .carry(c4), .shift_flag(f4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample_flags(input int k);
    if (f1) begin n1++; if (e1 == 0) e1 = k; if (p1) consec++; end
    if (f4) begin n4++; if (e4 == 0) e4 = k; if (p4) consec++; end
    p1 = f1;
    p4 = f4;
    if (b1) bc1++;
  endtask

  // Drive a request for one edge, then scramble inputs to prove they were latched.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic sel,
                        input logic [2:0] op, input logic [4:0] amt);
    @(negedge CLK);
    A = a; B = b; SEL = sel; OP = op; AMT = amt; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; A = ~a; B = ~b; SEL = ~sel; OP = ~op; AMT = ~amt;
    e1 = 0; e4 = 0; n1 = 0; n4 = 0; bc1 = 0;
    sample_flags(0);
  endtask

  task automatic wait_done(input int budget);
    for (int k = 1; k <= budget; k++) begin
      @(posedge CLK); #1;
      sample_flags(k);
      if (e1 != 0 && e4 != 0 && !b1 && !b4) break;
    end
  endtask

  initial begin
    // Reset
    #2 RST = 1'b1;
    #1;
    chk("rst_busy", {b4, b1}, 2'b00);
    chk("rst_flag", {f4, f1}, 2'b00);
    chk("rst_out", {so4, so1}, 32'h0);
    chk("rst_carry", {c4, c1}, 2'b00);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // LSR 8001 by 1
    launch(16'h8001, 16'h0000, 1'b0, 3'b000, 5'd1);
    wait_done(40);
    chk("lsr1_edge_u1", e1, 2);
    chk("lsr1_out_u1", {c1, so1}, {1'b1, 16'h4000});
    chk("lsr1_edge_u4", e4, 2);
    chk("lsr1_out_u4", {c4, so4}, {1'b1, 16'h4000});

    // ASR B=F000 by 4
    launch(16'h0000, 16'hF000, 1'b1, 3'b010, 5'd4);
    chk("asr4_hold_out", so1, 16'h4000);
    wait_done(40);
    chk("asr4_edge_u1", e1, 5);
    chk("asr4_busy_u1", bc1, 5);
    chk("asr4_out_u1", {c1, so1}, {1'b0, 16'hFF00});
    chk("asr4_edge_u4", e4, 2);
    chk("asr4_out_u4", {c4, so4}, {1'b0, 16'hFF00});

    // LSL 00FF by 9
    launch(16'h00FF, 16'h0000, 1'b0, 3'b001, 5'd9);
    wait_done(40);
    chk("lsl9_edge_u4", e4, 4);
    chk("lsl9_out_u4", {c4, so4}, {1'b1, 16'hFE00});
    chk("lsl9_edge_u1", e1, 10);
    chk("lsl9_out_u1", {c1, so1}, {1'b1, 16'hFE00});

    // ROR 0001 by 17
    launch(16'h0001, 16'h0000, 1'b0, 3'b100, 5'd17);
    wait_done(40);
`ifdef SEQ_SHIFT_ROTATE_EN
    chk("ror17_edge_u1", e1, 2);
    chk("ror17_out_u1", {c1, so1}, {1'b1, 16'h8000});
    chk("ror17_out_u4", {c4, so4}, {1'b1, 16'h8000});
`else
    chk("ror17_edge_u1", e1, 1);
    chk("ror17_out_u1", {c1, so1}, {1'b0, 16'h0001});
    chk("ror17_out_u4", {c4, so4}, {1'b0, 16'h0001});
`endif

    // ROL 1001 by 4
    launch(16'h1001, 16'h0000, 1'b0, 3'b101, 5'd4);
    wait_done(40);
`ifdef SEQ_SHIFT_ROTATE_EN
    chk("rol4_edge_u1", e1, 5);
    chk("rol4_out_u1", {c1, so1}, {1'b1, 16'h0011});
    chk("rol4_edge_u4", e4, 2);
    chk("rol4_out_u4", {c4, so4}, {1'b1, 16'h0011});
`else
    chk("rol4_edge_u1", e1, 1);
    chk("rol4_out_u1", {c1, so1}, {1'b0, 16'h1001});
    chk("rol4_edge_u4", e4, 1);
    chk("rol4_out_u4", {c4, so4}, {1'b0, 16'h1001});
`endif

    // Zero amount
    launch(16'h1234, 16'h0000, 1'b0, 3'b001, 5'd0);
    wait_done(40);
    chk("amt0_edge", {e4[7:0], e1[7:0]}, {8'd1, 8'd1});
    chk("amt0_out_u1", {c1, so1}, {1'b0, 16'h1234});

    // LSR clamps 20 to 16
    launch(16'hFFFF, 16'h0000, 1'b0, 3'b000, 5'd20);
    wait_done(40);
    chk("lsr20_edge", {e4[7:0], e1[7:0]}, {8'd5, 8'd17});
    chk("lsr20_out_u1", {c1, so1}, {1'b1, 16'h0000});
    chk("lsr20_out_u4", {c4, so4}, {1'b1, 16'h0000});

    // ASR clamps 31 to 16, sign fill
    launch(16'h8000, 16'h0000, 1'b0, 3'b010, 5'd31);
    wait_done(40);
    chk("asr31_edge", {e4[7:0], e1[7:0]}, {8'd5, 8'd17});
    chk("asr31_out_u1", {c1, so1}, {1'b1, 16'hFFFF});
    chk("asr31_out_u4", {c4, so4}, {1'b1, 16'hFFFF});

    // Undefined OP is a no-op
    launch(16'hABCD, 16'h0000, 1'b0, 3'b011, 5'd5);
    wait_done(40);
    chk("noop_edge", {e4[7:0], e1[7:0]}, {8'd1, 8'd1});
    chk("noop_out_u4", {c4, so4}, {1'b0, 16'hABCD});

    // start held through busy: one flag per accepted start
    @(negedge CLK);
    A = 16'h0004; SEL = 1'b0; OP = 3'b000; AMT = 5'd2; start = 1'b1;
    e1 = 0; e4 = 0; n1 = 0; n4 = 0; bc1 = 0;
    for (int k = 0; k <= 12; k++) begin
      @(posedge CLK); #1;
      sample_flags(k);
      if (k == 2) start = 1'b0;
    end
    chk("hold_edge", {e4[7:0], e1[7:0]}, {8'd2, 8'd3});
    chk("hold_count", {n4[7:0], n1[7:0]}, {8'd1, 8'd1});
    chk("hold_out_u1", {c1, so1}, {1'b0, 16'h0001});

    // Reset mid-operation
    launch(16'h00FF, 16'h0000, 1'b0, 3'b001, 5'd8);
    @(posedge CLK); #1;
    @(posedge CLK); #3;
    RST = 1'b1;
    #1;
    chk("midrst_busy", {b4, b1}, 2'b00);
    chk("midrst_out", {so4, so1}, 32'h0);
    chk("midrst_flag_carry", {f4, f1, c4, c1}, 4'b0000);
    @(negedge CLK);
    RST = 1'b0;
    e1 = 0; e4 = 0; n1 = 0; n4 = 0;
    wait_done(12);
    chk("midrst_noflag", {n4[7:0], n1[7:0]}, 16'h0);

    launch(16'h8001, 16'h0000, 1'b0, 3'b000, 5'd1);
    wait_done(40);
    chk("after_rst_edge", {e4[7:0], e1[7:0]}, {8'd2, 8'd2});
    chk("after_rst_out", {c1, so1}, {1'b1, 16'h4000});

    chk("flag_consecutive", consec, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
